moving_average_filter: RTL and testbench

- Multi-channel boxcar low-pass filter for IMU sensor data; sits between the sensor readout block and the motor-control logic.
- Proper synchronous design: one clock, sample-valid strobe in, data-ready pulse out.
- Circular sample buffer with a running sum per channel, so there is no full re-summation each sample.
- One shared add/subtract datapath serves all channels in turn.
- Adds over the previous generation: parametrised width, depth and channel count; power-of-two divide; zero-fill clear sequence; flush; primed and overrun status.

---
 rtl/filter_pkg.sv | 22 ++
 rtl/sample_ring_buffer.sv | 41 ++++
 rtl/moving_average_filter.sv | 171 +++++++++++++++++
 tb/tb_moving_average_filter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared definitions for the moving-average filter slice.
// Contents: FSM state encoding, running-sum width helper, default parameters.
// No logic; imported by sample_ring_buffer and moving_average_filter.
package filter_pkg;

  localparam int DEF_NUM_CH     = 3;
  localparam int DEF_DATA_W     = 10;
  localparam int DEF_LOG2_DEPTH = 8;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    ACCUM,
    DONE
  } state_t;

  // A window of 2**log2_depth signed samples needs log2_depth extra bits.
  function automatic int sum_width(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// Purpose: DEPTH x NUM_CH sample store backing the boxcar window.
// Latency: combinational read of (row, col); writes land on the rising clk edge.
// Backpressure: none; the owner sequences zero-row and single-entry writes.
// Ports: clk; zero_en/zero_row clear a whole row; wr_en/row/col/wr_data write
//        one entry; rd_data returns entry (row, col).
module sample_ring_buffer
  import filter_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LOG2_DEPTH = DEF_LOG2_DEPTH,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     zero_en,
  input  logic [LOG2_DEPTH-1:0]    zero_row,
  input  logic                     wr_en,
  input  logic [LOG2_DEPTH-1:0]    row,
  input  logic [CH_W-1:0]          col,
  input  logic signed [DATA_W-1:0] wr_data,
  output logic signed [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  // Storage is deliberately not reset: the CLEAR sequence zero-fills it.
  logic signed [DATA_W-1:0] mem [DEPTH][NUM_CH];

  assign rd_data = mem[row][col];

  always_ff @(posedge clk) begin
    if (zero_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mem[zero_row][c] <= '0;
      end
    end else if (wr_en) begin
      mem[row][col] <= wr_data;
    end
  end

endmodule

// File: rtl/moving_average_filter.sv
// Purpose: multi-channel boxcar low-pass (running sum over 2**LOG2_DEPTH samples).
// Latency: accept at edge t -> AvgOut/DataReady at edge t+NUM_CH+1; one sample per NUM_CH+2 cycles.
// Backpressure: SampleReady high only in IDLE; samples offered otherwise are dropped and set Overrun.
// Ports: Clock, Reset_n (async, active-low), Flush, SampleValid/SampleIn in;
//        SampleReady, AvgOut, DataReady, Primed, Overrun out.
// Option: define MOVING_AVERAGE_ROUNDING_EN for round-half-up instead of floor.
module moving_average_filter
  import filter_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LOG2_DEPTH = DEF_LOG2_DEPTH
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     Flush,
  input  logic                     SampleValid,
  input  logic [NUM_CH*DATA_W-1:0] SampleIn,
  output logic                     SampleReady,
  output logic [NUM_CH*DATA_W-1:0] AvgOut,
  output logic                     DataReady,
  output logic                     Primed,
  output logic                     Overrun
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = sum_width(DATA_W, LOG2_DEPTH);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [LOG2_DEPTH:0] FULL    = (LOG2_DEPTH + 1)'(DEPTH);
  localparam logic [CH_W-1:0]     LAST_CH = CH_W'(NUM_CH - 1);

  state_t                   state;
  logic [LOG2_DEPTH-1:0]    ptr;
  logic [LOG2_DEPTH-1:0]    row_cnt;
  logic [LOG2_DEPTH:0]      fill;
  logic [CH_W-1:0]          ch;
  logic signed [DATA_W-1:0] hold       [NUM_CH];
  logic signed [SUM_W-1:0]  sums       [NUM_CH];
  logic signed [DATA_W-1:0] avg_shadow [NUM_CH];

  logic signed [DATA_W-1:0] old_s;
  logic signed [DATA_W-1:0] new_s;
  logic signed [SUM_W-1:0]  sum_next;
  logic signed [DATA_W-1:0] avg_next;

  sample_ring_buffer #(
    .NUM_CH     (NUM_CH),
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH),
    .CH_W       (CH_W)
  ) u_buf (
    .clk      (Clock),
    .zero_en  (state == CLEAR),
    .zero_row (row_cnt),
    .wr_en    (state == ACCUM),
    .row      (ptr),
    .col      (ch),
    .wr_data  (new_s),
    .rd_data  (old_s)
  );

`ifdef MOVING_AVERAGE_ROUNDING_EN
  localparam logic [SUM_W:0] HALF = (SUM_W + 1)'(1) << (LOG2_DEPTH - 1);
  logic signed [SUM_W:0] rnd;
`endif

  // Shared datapath: one channel per ACCUM cycle. The oldest sample leaves the
  // sum in the same step the new one enters, so no re-summation is needed.
  always_comb begin
    new_s    = hold[ch];
    sum_next = sums[ch]
             + {{LOG2_DEPTH{new_s[DATA_W-1]}}, new_s}
             - {{LOG2_DEPTH{old_s[DATA_W-1]}}, old_s};
`ifdef MOVING_AVERAGE_ROUNDING_EN
    // One extra bit so the half-LSB bias cannot wrap the largest sum.
    rnd      = {sum_next[SUM_W-1], sum_next} + HALF;
    avg_next = rnd[SUM_W-1:LOG2_DEPTH];
`else
    // Taking the top DATA_W bits is the arithmetic shift by LOG2_DEPTH.
    avg_next = sum_next[SUM_W-1:LOG2_DEPTH];
`endif
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= CLEAR;
      ptr         <= '0;
      row_cnt     <= '0;
      fill        <= '0;
      ch          <= '0;
      SampleReady <= 1'b0;
      AvgOut      <= '0;
      DataReady   <= 1'b0;
      Primed      <= 1'b0;
      Overrun     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        hold[i]       <= '0;
        sums[i]       <= '0;
        avg_shadow[i] <= '0;
      end
    end else begin
      DataReady <= 1'b0;
      if (SampleValid && !SampleReady && !Flush) begin
        Overrun <= 1'b1;
      end

      if (Flush) begin
        // Abort whatever is in flight; AvgOut keeps its last published value.
        state       <= CLEAR;
        SampleReady <= 1'b0;
        row_cnt     <= '0;
        ptr         <= '0;
        fill        <= '0;
        ch          <= '0;
        Primed      <= 1'b0;
        Overrun     <= 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
          sums[i] <= '0;
        end
      end else begin
        case (state)
          CLEAR: begin
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == '1) begin
              state       <= IDLE;
              SampleReady <= 1'b1;
            end
          end
          IDLE: begin
            if (SampleValid) begin
              for (int i = 0; i < NUM_CH; i++) begin
                hold[i] <= SampleIn[i*DATA_W +: DATA_W];
              end
              ch          <= '0;
              state       <= ACCUM;
              SampleReady <= 1'b0;
            end
          end
          ACCUM: begin
            sums[ch]       <= sum_next;
            avg_shadow[ch] <= avg_next;
            if (ch == LAST_CH) begin
              ptr   <= ptr + 1'b1;
              if (fill != FULL) begin
                fill <= fill + 1'b1;
              end
              state <= DONE;
            end else begin
              ch <= ch + 1'b1;
            end
          end
          DONE: begin
            for (int i = 0; i < NUM_CH; i++) begin
              AvgOut[i*DATA_W +: DATA_W] <= avg_shadow[i];
            end
            DataReady   <= 1'b1;
            Primed      <= (fill == FULL);
            state       <= IDLE;
            SampleReady <= 1'b1;
          end
          default: begin
            state       <= CLEAR;
            SampleReady <= 1'b0;
            row_cnt     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_moving_average_filter.sv
module tb_moving_average_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef MOVING_AVERAGE_ROUNDING_EN
  localparam int EXP_TAIL = -1;  // sum -6, depth 4
  localparam int EXP_HALF = 0;   // sum -4, depth 8
`else
  localparam int EXP_TAIL = -2;
  localparam int EXP_HALF = -1;
`endif

  logic        rst_n;
  logic        flush4, valid4, rdy4, dr4, pr4, ov4;
  logic [29:0] in4, avg4;
  logic        flush8, valid8, rdy8, dr8, pr8, ov8;
  logic [29:0] in8, avg8;

  moving_average_filter #(.NUM_CH(3), .DATA_W(10), .LOG2_DEPTH(2)) u4 (
    .Clock(clk), .Reset_n(rst_n), .Flush(flush4), .SampleValid(valid4),
    .SampleIn(in4), .SampleReady(rdy4), .AvgOut(avg4), .DataReady(dr4),
    .Primed(pr4), .Overrun(ov4)
  );

  moving_average_filter #(.NUM_CH(3), .DATA_W(10), .LOG2_DEPTH(3)) u8 (
    .Clock(clk), .Reset_n(rst_n), .Flush(flush8), .SampleValid(valid8),
    .SampleIn(in8), .SampleReady(rdy8), .AvgOut(avg8), .DataReady(dr8),
    .Primed(pr8), .Overrun(ov8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] ch_of(input logic [29:0] v, input int c);
    logic signed [9:0] t;
    t = v[c*10 +: 10];
    return 32'(t);
  endfunction

  // Offer one sample vector to the selected instance and wait for its result.
  task automatic feed(input bit sel8, input int a, input int b, input int c);
    int n;
    logic [29:0] v;
    v = {c[9:0], b[9:0], a[9:0]};
    n = 0;
    while (!(sel8 ? rdy8 : rdy4) && n < 60) begin tick(); n++; end
    chk("ready_wait_in_budget", 32'(n < 60), 1);
    if (sel8) begin in8 = v; valid8 = 1'b1; end
    else      begin in4 = v; valid4 = 1'b1; end
    tick();
    valid4 = 1'b0;
    valid8 = 1'b0;
    n = 0;
    while (!(sel8 ? dr8 : dr4) && n < 20) begin tick(); n++; end
    chk("datardy_latency", n, 4);
  endtask

  initial begin
    int  k;
    bit  saw_dr;
    rst_n  = 1'b0;
    flush4 = 1'b0; valid4 = 1'b0; in4 = '0;
    flush8 = 1'b0; valid8 = 1'b0; in8 = '0;
    tick();
    tick();

    // Reset values
    chk("rst_ready", rdy4, 0);
    chk("rst_avg", avg4, 0);
    chk("rst_dataready", dr4, 0);
    chk("rst_primed", pr4, 0);
    chk("rst_overrun", ov4, 0);
    chk("rst_ready8", rdy8, 0);

    // CLEAR lasts DEPTH=4 cycles after release
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("clear_ready_c%0d", i), rdy4, (i == 4) ? 1 : 0);
    end
    chk("clear_avg", avg4, 0);
    chk("clear_primed", pr4, 0);

    // Warm-up ramp on ch0
    for (int i = 0; i < 4; i++) begin
      feed(1'b0, 100, 0, 0);
      chk($sformatf("ramp_avg_%0d", i), ch_of(avg4, 0), 25 * (i + 1));
      chk($sformatf("ramp_primed_%0d", i), pr4, (i == 3) ? 1 : 0);
    end
    chk("ramp_ch1", ch_of(avg4, 1), 0);

    // Window of -7, then one +1: sum -20 -> -5
    for (int i = 0; i < 4; i++) feed(1'b0, -7, -7, -7);
    chk("neg7_ch2", ch_of(avg4, 2), -7);
    chk("neg7_primed", pr4, 1);
    feed(1'b0, 1, 1, 1);
    chk("plus1_ch0", ch_of(avg4, 0), -5);
    chk("plus1_ch1", ch_of(avg4, 1), -5);
    chk("plus1_ch2", ch_of(avg4, 2), -5);

    // SampleValid held high: accepted only every 5th cycle
    in4 = '0;
    valid4 = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      chk($sformatf("hold_ready_%0d", i), rdy4, (i % 5 == 0) ? 1 : 0);
      tick();
      if (i == 0) chk("overrun_after_accept", ov4, 0);
      if (i == 1) chk("overrun_first_reject", ov4, 1);
    end
    valid4 = 1'b0;
    chk("hold_avg_ch0", ch_of(avg4, 0), EXP_TAIL);

    // Flush mid-ACCUM
    tick();
    flush4 = 1'b1;
    tick();
    flush4 = 1'b0;
    chk("flush_overrun", ov4, 0);
    chk("flush_primed", pr4, 0);
    chk("flush_ready", rdy4, 0);
    saw_dr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dr4) saw_dr = 1'b1;
    end
    chk("flush_no_dataready", saw_dr, 0);
    chk("flush_avg_hold", ch_of(avg4, 0), EXP_TAIL);
    chk("flush_ready_after_clear", rdy4, 1);
    feed(1'b0, 8, 8, 8);
    chk("post_flush_ch0", ch_of(avg4, 0), 2);
    chk("post_flush_ch2", ch_of(avg4, 2), 2);

    // Full-scale stress, depth 8
    for (k = 0; k < 16; k++) begin
      feed(1'b1, (k < 8) ? 511 : -512, (k < 8) ? -512 : 511, 0);
      if (k == 6) chk("fs_primed_7", pr8, 0);
      if (k == 7) begin
        chk("fs_max_ch0", ch_of(avg8, 0), 511);
        chk("fs_min_ch1", ch_of(avg8, 1), -512);
        chk("fs_primed_8", pr8, 1);
      end
      if (k == 11) chk("fs_mixed_ch0", ch_of(avg8, 0), EXP_HALF);
      if (k == 15) begin
        chk("fs_min_ch0", ch_of(avg8, 0), -512);
        chk("fs_max_ch1", ch_of(avg8, 1), 511);
      end
    end
    chk("fs_overrun", ov8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
